// File: rtl/regfile_dump_reader.sv
// Debug read-out engine: walks the register file in ascending order through a
// spare read port and streams each word as {num,data} over valid/ready.
module regfile_dump_reader #(
    parameter int NUM_REGS  = 32,
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 32,
    parameter int SKIP_ZERO = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] rd_num,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_num,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] FIRST = (SKIP_ZERO != 0) ? ADDR_W'(1) : ADDR_W'(0);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] rd_num_q;
    logic [ADDR_W-1:0] out_num_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_valid_q;
    logic              busy_q;
    logic              done_q;

    // Scan FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            rd_num_q    <= '0;
            out_num_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort && (state_q != IDLE)) begin
                // Abort wins over a same-cycle handshake; the offered word is dropped.
                state_q     <= IDLE;
                rd_num_q    <= '0;
                out_valid_q <= 1'b0;
                busy_q      <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        rd_num_q <= '0;
                        if (start && !abort) begin
                            idx_q    <= FIRST;
                            rd_num_q <= FIRST;
                            busy_q   <= 1'b1;
                            state_q  <= FETCH;
                        end else begin
                            busy_q <= 1'b0;
                        end
                    end
                    FETCH: begin
                        out_data_q  <= rd_data;
                        out_num_q   <= idx_q;
                        out_valid_q <= 1'b1;
                        state_q     <= HOLD;
                    end
                    HOLD: begin
                        if (out_ready) begin
                            out_valid_q <= 1'b0;
                            if (idx_q == LAST) begin
                                done_q  <= 1'b1;
                                state_q <= DONE;
                            end else begin
                                idx_q    <= idx_q + ADDR_W'(1);
                                rd_num_q <= idx_q + ADDR_W'(1);
                                state_q  <= FETCH;
                            end
                        end else begin
                            out_valid_q <= 1'b1;
                        end
                    end
                    DONE: begin
                        rd_num_q <= '0;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end
                    default: begin
                        rd_num_q    <= '0;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                endcase
            end
        end
    end

    assign rd_num    = rd_num_q;
    assign out_valid = out_valid_q;
    assign out_num   = out_num_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader: full dump, backpressure, SKIP_ZERO,
// abort, stray start and asynchronous reset mid-scan.
module tb_regfile_dump_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start_a, start_b, abort, out_ready;
    logic [4:0]  rd_num_a, rd_num_b, out_num_a, out_num_b;
    logic [31:0] rd_data_a, rd_data_b, out_data_a, out_data_b;
    logic        valid_a, valid_b, busy_a, busy_b, done_a, done_b;
    logic [31:0] regs [32];

    assign rd_data_a = regs[rd_num_a];
    assign rd_data_b = regs[rd_num_b];

    regfile_dump_reader #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .SKIP_ZERO(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort),
        .rd_num(rd_num_a), .rd_data(rd_data_a), .out_valid(valid_a),
        .out_ready(out_ready), .out_num(out_num_a), .out_data(out_data_a),
        .busy(busy_a), .done(done_a)
    );

    regfile_dump_reader #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .SKIP_ZERO(1)) dut_sz (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort),
        .rd_num(rd_num_b), .rd_data(rd_data_b), .out_valid(valid_b),
        .out_ready(out_ready), .out_num(out_num_b), .out_data(out_data_b),
        .busy(busy_b), .done(done_b)
    );

    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;
    logic sel    = 1'b0;

    logic        o_valid, o_busy, o_done;
    logic [4:0]  o_num, o_rd;
    logic [31:0] o_data;

    // Route the instance under test to a common set of observation signals.
    always_comb begin
        if (sel) begin
            o_valid = valid_b; o_busy = busy_b; o_done = done_b;
            o_num = out_num_b; o_rd = rd_num_b; o_data = out_data_b;
        end else begin
            o_valid = valid_a; o_busy = busy_a; o_done = done_a;
            o_num = out_num_a; o_rd = rd_num_a; o_data = out_data_a;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_start(input logic s, input logic v);
        if (s) start_b = v;
        else   start_a = v;
    endtask

    // One scan with out_ready held high except for an optional stall on word
    // stall_k, plus an optional stray start pulse at cycle stray.
    task automatic scan(input logic s, input int first, input int stall_k,
                        input int stall_n, input int stray);
        int k = 0;
        int done_cyc = -1;
        int done_cnt = 0;
        int stall_left = 0;
        int nwords = 32 - first;
        int extra;
        bit fresh = 1'b1;
        sel = s;
        out_ready = 1'b1;
        set_start(s, 1'b1);
        cyc = 0;
        tick();
        set_start(s, 1'b0);
        while (cyc < 2 * nwords + stall_n + 6) begin
            set_start(s, cyc == stray);
            if (o_valid) begin
                check_eq("out_num", 64'(o_num), 64'(first + k));
                check_eq("out_data", 64'(o_data), 64'(32'hA5A5_0000 + 32'(first + k)));
                if (fresh) begin
                    extra = (stall_k >= 0 && k > stall_k) ? stall_n : 0;
                    check_eq("valid_cycle", 64'(cyc), 64'(2 * k + 2 + extra));
                    fresh = 1'b0;
                    if (k == stall_k) stall_left = stall_n;
                end
            end
            if (o_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (cyc == 2 * nwords + 2 + stall_n) check_eq("busy_after_done", 64'(o_busy), 64'(0));
            out_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            if (o_valid && out_ready) begin
                k++;
                fresh = 1'b1;
            end
            tick();
        end
        set_start(s, 1'b0);
        out_ready = 1'b1;
        check_eq("word_count", 64'(k), 64'(nwords));
        check_eq("done_cycle", 64'(done_cyc), 64'(2 * nwords + 1 + stall_n));
        check_eq("done_pulses", 64'(done_cnt), 64'(1));
        check_eq("idle_rd_num", 64'(o_rd), 64'(0));
    endtask

    initial begin
        int dcnt;
        for (int i = 0; i < 32; i++) regs[i] = 32'hA5A5_0000 + 32'(i);
        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; abort = 1'b0; out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        check_eq("rst_valid", 64'(valid_a), 64'(0));
        check_eq("rst_busy", 64'(busy_a), 64'(0));
        check_eq("rst_done", 64'(done_a), 64'(0));
        check_eq("rst_rd_num", 64'(rd_num_a), 64'(0));
        check_eq("rst_busy_sz", 64'(busy_b), 64'(0));

        // start together with abort in IDLE stays idle
        start_a = 1'b1; abort = 1'b1;
        tick();
        start_a = 1'b0; abort = 1'b0;
        check_eq("start_abort_idle", 64'(busy_a), 64'(0));
        tick();

        // Full dump, backpressure on word 3, SKIP_ZERO, stray start at cycle 20
        scan(1'b0, 0, -1, 0, -1);
        tick();
        scan(1'b0, 0, 3, 5, -1);
        tick();
        scan(1'b1, 1, -1, 0, -1);
        tick();
        scan(1'b0, 0, -1, 0, 20);
        tick();

        // Abort while word 10 is held without ready
        sel = 1'b0; out_ready = 1'b1; start_a = 1'b1; cyc = 0;
        tick();
        start_a = 1'b0;
        while (!(o_valid && o_num == 5'd10) && cyc < 40) tick();
        check_eq("abort_word10_cycle", 64'(cyc), 64'(22));
        out_ready = 1'b0;
        tick();
        check_eq("abort_hold_valid", 64'(o_valid), 64'(1));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("abort_valid", 64'(o_valid), 64'(0));
        check_eq("abort_busy", 64'(o_busy), 64'(0));
        dcnt = 0;
        repeat (6) begin
            if (o_done) dcnt++;
            tick();
        end
        check_eq("abort_no_done", 64'(dcnt), 64'(0));
        out_ready = 1'b1;
        scan(1'b0, 0, -1, 0, -1);
        tick();

        // Asynchronous reset at cycle 30 of a scan
        sel = 1'b0; start_a = 1'b1; cyc = 0;
        tick();
        start_a = 1'b0;
        while (cyc < 30) tick();
        check_eq("pre_rst_busy", 64'(o_busy), 64'(1));
        rst_n = 1'b0;
        #1;
        check_eq("arst_valid", 64'(o_valid), 64'(0));
        check_eq("arst_busy", 64'(o_busy), 64'(0));
        check_eq("arst_done", 64'(o_done), 64'(0));
        check_eq("arst_rd_num", 64'(o_rd), 64'(0));
        check_eq("arst_out_num", 64'(o_num), 64'(0));
        check_eq("arst_out_data", 64'(o_data), 64'(0));
        tick();
        rst_n = 1'b1;
        dcnt = 0;
        repeat (40) begin
            if (o_done || o_busy) dcnt++;
            tick();
        end
        check_eq("post_rst_quiet", 64'(dcnt), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
